// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the shared memory port and mem_port_arbiter.
// Handshake: a requester holds req_x (with stable addr/we/wdata) until it sees ack_x or err_x;
// the memory completes the active transaction by raising mem_ready while mem_valid is high.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req_0;
  logic             req_1;
  logic [WIDTH-1:0] addr_0;
  logic [WIDTH-1:0] addr_1;
  logic             we_0;
  logic             we_1;
  logic [WIDTH-1:0] wdata_0;
  logic [WIDTH-1:0] wdata_1;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;
  logic             sel;
  logic             mem_valid;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] rdata;
  logic             ack_0;
  logic             ack_1;
  logic             err_0;
  logic             err_1;
  logic [1:0]       dbg_state;

  // Arbiter side.
  modport slave (
    input  req_0, req_1, addr_0, addr_1, we_0, we_1, wdata_0, wdata_1,
    input  mem_ready, mem_rdata,
    output sel, mem_valid, mem_addr, mem_we, mem_wdata, rdata,
    output ack_0, ack_1, err_0, err_1, dbg_state
  );

  // Requesters and memory side.
  modport master (
    output req_0, req_1, addr_0, addr_1, we_0, we_1, wdata_0, wdata_1,
    output mem_ready, mem_rdata,
    input  sel, mem_valid, mem_addr, mem_we, mem_wdata, rdata,
    input  ack_0, ack_1, err_0, err_1, dbg_state
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and load/store (port 1), with a registered transaction and a BUSY timeout watchdog.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic [CW-1:0]    cnt;

  logic             any_req;
  logic             win;
  logic             grant;
  logic             complete;
  logic             expire;

  logic             sel_q;
  logic             mem_valid_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic             mem_we_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             ack_0_q;
  logic             ack_1_q;
  logic             err_0_q;
  logic             err_1_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = BUSY;
      BUSY: if (bus.mem_ready || cnt == CNT_LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decode: a tie goes to the port that did not win last time.
  always_comb begin
    any_req  = 1'b0;
    win      = 1'b0;
    grant    = 1'b0;
    complete = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        any_req = bus.req_0 | bus.req_1;
        win     = bus.req_1 & (~bus.req_0 | ~last);
        grant   = any_req;
      end
      BUSY: begin
        complete = bus.mem_ready;
        expire   = ~bus.mem_ready & (cnt == CNT_LAST);
      end
      default: begin
        any_req = 1'b0;
      end
    endcase
  end

  // Transaction registers; ack/err are set on the edge into DONE and cleared on the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 1'b0;
      last        <= 1'b1;
      cnt         <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ack_0_q     <= 1'b0;
      ack_1_q     <= 1'b0;
      err_0_q     <= 1'b0;
      err_1_q     <= 1'b0;
    end else begin
      ack_0_q <= 1'b0;
      ack_1_q <= 1'b0;
      err_0_q <= 1'b0;
      err_1_q <= 1'b0;
      if (grant) begin
        sel_q       <= win;
        last        <= win;
        cnt         <= '0;
        mem_valid_q <= 1'b1;
        mem_addr_q  <= win ? bus.addr_1  : bus.addr_0;
        mem_we_q    <= win ? bus.we_1    : bus.we_0;
        mem_wdata_q <= win ? bus.wdata_1 : bus.wdata_0;
      end
      if (state == BUSY && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (complete) begin
        rdata_q     <= bus.mem_rdata;
        ack_0_q     <= ~sel_q;
        ack_1_q     <= sel_q;
        mem_valid_q <= 1'b0;
      end else if (expire) begin
        err_0_q     <= ~sel_q;
        err_1_q     <= sel_q;
        mem_valid_q <= 1'b0;
      end
    end
  end

  assign bus.sel       = sel_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.ack_0     = ack_0_q;
  assign bus.ack_1     = ack_1_q;
  assign bus.err_0     = err_0_q;
  assign bus.err_1     = err_1_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 32-bit memory port between two requesters: instruction fetch (port 0) and load/store (port 1).
- Grants the port to one requester at a time.
- Drives the select line of the shared 2:1 address/data mux and registers the winner's transaction onto the memory interface.
- Sequences a valid/ready handshake with the memory, with a timeout watchdog.

Parameters:
WIDTH, 32, data/address width
TIMEOUT, 16, max cycles in BUSY waiting for MEM_READY before abort (>=2)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, asynchronous, active-low
REQ_0, REQ_1  input  1  level request; held until ACK_x/ERR_x
ADDR_0, ADDR_1  input  WIDTH  request address
WE_0, WE_1  input  1  1 = write, 0 = read
WDATA_0, WDATA_1  input  WIDTH  write data
MEM_READY  input  1  memory completion strobe
MEM_RDATA  input  WIDTH  memory read data, valid with MEM_READY
SEL  output  1  shared-mux select (0 = port 0, 1 = port 1)
MEM_VALID  output  1  transaction active on memory port
MEM_ADDR  output  WIDTH  registered address
MEM_WE  output  1  registered write enable
MEM_WDATA  output  WIDTH  registered write data
RDATA  output  WIDTH  captured read data
ACK_0, ACK_1  output  1  one-cycle completion pulse
ERR_0, ERR_1  output  1  one-cycle timeout pulse

Behaviour:
- Reset (RST_N low, immediate, async):
  - state IDLE, SEL=0, MEM_VALID=0, MEM_WE=0.
  - MEM_ADDR, MEM_WDATA and RDATA = 0.
  - ACK_x=0, ERR_x=0, cnt=0.
  - LAST=1, so port 0 wins the first tie.
- Reset mid-transaction: abort silently, no ACK/ERR pulse. The memory sees MEM_VALID drop asynchronously.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No REQ: stay in IDLE, all outputs hold.
  - Exactly one REQ_x high: winner is x.
  - Both high: winner is !LAST (round-robin).
  - On the edge with a winner w: SEL<=w, LAST<=w, MEM_VALID<=1, cnt<=0, go BUSY.
  - Also on that edge, capture MEM_ADDR/MEM_WE/MEM_WDATA from ADDR_w/WE_w/WDATA_w.
- BUSY:
  - MEM_VALID=1 and SEL, MEM_ADDR, MEM_WE, MEM_WDATA held stable.
  - cnt increments by 1 each cycle.
  - If MEM_READY=1, on the next edge:
    - RDATA<=MEM_RDATA (also on writes).
    - ACK_w<=1, MEM_VALID<=0, go DONE.
  - Else if cnt==TIMEOUT-1, on the next edge: ERR_w<=1, MEM_VALID<=0, RDATA unchanged, go DONE.
  - If MEM_READY and timeout coincide, MEM_READY wins (ACK, not ERR).
  - REQ deasserting during BUSY does not abort; the transaction completes normally.
  - The other requester's REQ is ignored.
- DONE:
  - Lasts exactly one cycle, with ACK_w or ERR_w high during it.
  - Next edge: clear ACK/ERR, go IDLE. SEL holds its last value.
  - REQ inputs are not sampled in DONE.
  - A requester that keeps REQ high through DONE is treated as a new request in IDLE.
- MEM_READY outside BUSY is ignored.
- Latency and throughput:
  - REQ high in IDLE cycle c gives MEM_VALID in c+1.
  - MEM_READY in c+1 gives ACK in c+2 and IDLE in c+3.
  - Minimum 3 cycles per transaction.
- ACK_0/ACK_1/ERR_0/ERR_1 are mutually exclusive and never high outside DONE.
- cnt width: $clog2(TIMEOUT+1); cnt never wraps.

Test Plan:
1. Reset state:
   - Stimulus: assert RST_N=0 mid-BUSY (REQ_0, ADDR_0=0x100).
   - Required response: immediately MEM_VALID=0, SEL=0, RDATA=0, no ACK. After release with REQ_1 only, SEL=1 on first grant.
2. Single read:
   - Stimulus: REQ_0, ADDR_0=0x0000_0040, WE_0=0; MEM_READY one cycle after MEM_VALID with MEM_RDATA=0xDEAD_BEEF.
   - Required response: MEM_ADDR=0x40, RDATA=0xDEADBEEF, ACK_0 high exactly 1 cycle, 3-cycle total.
3. Round-robin tie:
   - Stimulus: REQ_0 and REQ_1 both held high for 4 transactions, MEM_READY immediate.
   - Required response: grant order 0,1,0,1; SEL toggles accordingly; each ACK_x pulses once per grant.
4. Write with stall:
   - Stimulus: REQ_1, WE_1=1, WDATA_1=0x1234_5678, ADDR_1=0x200; MEM_READY after 5 BUSY cycles.
   - Required response: MEM_WDATA/MEM_ADDR/MEM_WE stable for all 5 cycles; ACK_1 pulse.
   - Also toggle WDATA_1 during BUSY; MEM_WDATA must not change.
5. Timeout:
   - Stimulus: REQ_0, never assert MEM_READY, TIMEOUT=16.
   - Required response: MEM_VALID high exactly 16 cycles, then ERR_0 one pulse, RDATA unchanged, return to IDLE.
   - Repeat with MEM_READY on the 16th BUSY cycle: ACK_0, no ERR_0.
6. Spurious/early drop:
   - Stimulus: MEM_READY pulses in IDLE; REQ_1 dropped mid-BUSY.
   - Required response: no ACK from the spurious pulses. The dropped transaction still completes with ACK_1.
